// File: rtl/alu_reservation_station.sv
// rtl/alu_reservation_station.sv - ALU reservation station with CDB snooping and lowest-index dispatch
//
// Holds renamed ALU instructions until both operands are ready, then
// dispatches one ready entry per cycle to the ALU.
//
// Ports:
//   clk, rst (async, active-low), rdy (global stall when 0), clear (flush)
//   issue_*        : incoming instruction with operand values/tags
//   full           : every entry is busy (start-of-cycle view)
//   alu_cdb_*      : ALU result broadcast
//   lsb_cdb_*      : load/store buffer result broadcast
//   alu_valid/op/v1/v2/rob_id : registered dispatch to the ALU

`ifndef ROB_SIZE_WIDTH
`define ROB_SIZE_WIDTH 4
`endif

module alu_reservation_station #(
  parameter int RS_SIZE_WIDTH = 3
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       rdy,
  input  logic                       clear,
  input  logic                       issue_valid,
  input  logic [4:0]                 issue_op,
  input  logic [`ROB_SIZE_WIDTH-1:0] issue_rob_id,
  input  logic                       issue_qj_busy,
  input  logic                       issue_qk_busy,
  input  logic [`ROB_SIZE_WIDTH-1:0] issue_qj,
  input  logic [`ROB_SIZE_WIDTH-1:0] issue_qk,
  input  logic [31:0]                issue_vj,
  input  logic [31:0]                issue_vk,
  output logic                       full,
  input  logic                       alu_cdb_ready,
  input  logic [`ROB_SIZE_WIDTH-1:0] alu_cdb_rob_id,
  input  logic [31:0]                alu_cdb_result,
  input  logic                       lsb_cdb_ready,
  input  logic [`ROB_SIZE_WIDTH-1:0] lsb_cdb_rob_id,
  input  logic [31:0]                lsb_cdb_result,
  output logic                       alu_valid,
  output logic [4:0]                 alu_op,
  output logic [31:0]                alu_v1,
  output logic [31:0]                alu_v2,
  output logic [`ROB_SIZE_WIDTH-1:0] alu_rob_id
);

  localparam int RW = `ROB_SIZE_WIDTH;
  localparam int RS = 1 << RS_SIZE_WIDTH;

  logic [RS-1:0] busy, rj, rk;
  logic [4:0]    op     [RS];
  logic [RW-1:0] rob_id [RS];
  logic [RW-1:0] qj     [RS];
  logic [RW-1:0] qk     [RS];
  logic [31:0]   vj     [RS];
  logic [31:0]   vk     [RS];

  logic [RS_SIZE_WIDTH-1:0] free_idx, disp_idx;
  logic                     disp_found;

  // Snoop results per entry: {hit, value}. ALU bus takes priority over LSB.
  logic [32:0] snoop_j [RS];
  logic [32:0] snoop_k [RS];
  logic [32:0] iss_j, iss_k;

  function automatic logic [32:0] lookup(input logic [RW-1:0] tag);
    if (alu_cdb_ready && alu_cdb_rob_id == tag)
      return {1'b1, alu_cdb_result};
    else if (lsb_cdb_ready && lsb_cdb_rob_id == tag)
      return {1'b1, lsb_cdb_result};
    else
      return {1'b0, 32'd0};
  endfunction

  assign full = &busy;

  // Downward scan so the lowest index is the last (winning) assignment.
  always_comb begin
    free_idx   = '0;
    disp_idx   = '0;
    disp_found = 1'b0;
    for (int i = RS - 1; i >= 0; i--) begin
      if (!busy[i])
        free_idx = RS_SIZE_WIDTH'(i);
      if (busy[i] && rj[i] && rk[i]) begin
        disp_idx   = RS_SIZE_WIDTH'(i);
        disp_found = 1'b1;
      end
    end
  end

  always_comb begin
    for (int i = 0; i < RS; i++) begin
      snoop_j[i] = lookup(qj[i]);
      snoop_k[i] = lookup(qk[i]);
    end
  end

  // Issue-time operand: a pending tag broadcast this same cycle is captured now.
  always_comb begin
    iss_j = {1'b1, issue_vj};
    iss_k = {1'b1, issue_vk};
    if (issue_qj_busy)
      iss_j = lookup(issue_qj);
    if (issue_qk_busy)
      iss_k = lookup(issue_qk);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy       <= '0;
      rj         <= '0;
      rk         <= '0;
      alu_valid  <= 1'b0;
      alu_op     <= '0;
      alu_v1     <= '0;
      alu_v2     <= '0;
      alu_rob_id <= '0;
      for (int i = 0; i < RS; i++) begin
        op[i]     <= '0;
        rob_id[i] <= '0;
        qj[i]     <= '0;
        qk[i]     <= '0;
        vj[i]     <= '0;
        vk[i]     <= '0;
      end
    end else if (rdy) begin
      if (clear) begin
        busy      <= '0;
        alu_valid <= 1'b0;
      end else begin
        // Ready operands are never overwritten: capture only while pending.
        for (int i = 0; i < RS; i++) begin
          if (busy[i] && !rj[i] && snoop_j[i][32]) begin
            vj[i] <= snoop_j[i][31:0];
            rj[i] <= 1'b1;
          end
          if (busy[i] && !rk[i] && snoop_k[i][32]) begin
            vk[i] <= snoop_k[i][31:0];
            rk[i] <= 1'b1;
          end
        end

        if (disp_found) begin
          alu_valid      <= 1'b1;
          alu_op         <= op[disp_idx];
          alu_v1         <= vj[disp_idx];
          alu_v2         <= vk[disp_idx];
          alu_rob_id     <= rob_id[disp_idx];
          busy[disp_idx] <= 1'b0;
        end else begin
          alu_valid <= 1'b0;
        end

        // free_idx is never busy, so it cannot collide with disp_idx.
        if (issue_valid && !full) begin
          busy[free_idx]   <= 1'b1;
          op[free_idx]     <= issue_op;
          rob_id[free_idx] <= issue_rob_id;
          qj[free_idx]     <= issue_qj;
          qk[free_idx]     <= issue_qk;
          vj[free_idx]     <= iss_j[31:0];
          vk[free_idx]     <= iss_k[31:0];
          rj[free_idx]     <= iss_j[32];
          rk[free_idx]     <= iss_k[32];
        end
      end
    end
  end

endmodule

// File: tb/tb_alu_reservation_station.sv
// tb/tb_alu_reservation_station.sv - self-checking bench for alu_reservation_station

`ifndef ROB_SIZE_WIDTH
`define ROB_SIZE_WIDTH 4
`endif

module tb_alu_reservation_station;

  localparam int RW = `ROB_SIZE_WIDTH;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, rdy, clear;
  logic          issue_valid;
  logic [4:0]    issue_op;
  logic [RW-1:0] issue_rob_id, issue_qj, issue_qk;
  logic          issue_qj_busy, issue_qk_busy;
  logic [31:0]   issue_vj, issue_vk;
  logic          full;
  logic          alu_cdb_ready, lsb_cdb_ready;
  logic [RW-1:0] alu_cdb_rob_id, lsb_cdb_rob_id;
  logic [31:0]   alu_cdb_result, lsb_cdb_result;
  logic          alu_valid;
  logic [4:0]    alu_op;
  logic [31:0]   alu_v1, alu_v2;
  logic [RW-1:0] alu_rob_id;

  alu_reservation_station #(.RS_SIZE_WIDTH(3)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .clear(clear),
    .issue_valid(issue_valid), .issue_op(issue_op), .issue_rob_id(issue_rob_id),
    .issue_qj_busy(issue_qj_busy), .issue_qk_busy(issue_qk_busy),
    .issue_qj(issue_qj), .issue_qk(issue_qk),
    .issue_vj(issue_vj), .issue_vk(issue_vk),
    .full(full),
    .alu_cdb_ready(alu_cdb_ready), .alu_cdb_rob_id(alu_cdb_rob_id), .alu_cdb_result(alu_cdb_result),
    .lsb_cdb_ready(lsb_cdb_ready), .lsb_cdb_rob_id(lsb_cdb_rob_id), .lsb_cdb_result(lsb_cdb_result),
    .alu_valid(alu_valid), .alu_op(alu_op), .alu_v1(alu_v1), .alu_v2(alu_v2), .alu_rob_id(alu_rob_id)
  );

  // Reference model: a slot table of waiting instructions plus the last dispatch.
  typedef struct {
    logic          used;
    logic [4:0]    op;
    logic [RW-1:0] rob, tj, tk;
    logic          wj, wk;      // still waiting on tag
    logic [31:0]   vj, vk;
  } slot_t;

  slot_t         slots [8];
  logic          m_valid;
  logic [4:0]    m_op;
  logic [31:0]   m_v1, m_v2;
  logic [RW-1:0] m_rob;

  int passed = 0;
  int total  = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s got=%0h exp=%0h at %0t", name, got, exp, $time);
  endtask

  task automatic model_reset();
    for (int i = 0; i < 8; i++) begin
      slots[i].used = 1'b0; slots[i].op = '0; slots[i].rob = '0;
      slots[i].tj = '0; slots[i].tk = '0; slots[i].wj = 1'b0; slots[i].wk = 1'b0;
      slots[i].vj = '0; slots[i].vk = '0;
    end
    m_valid = 1'b0; m_op = '0; m_v1 = '0; m_v2 = '0; m_rob = '0;
  endtask

  function automatic int model_count();
    int n = 0;
    for (int i = 0; i < 8; i++) if (slots[i].used) n++;
    return n;
  endfunction

  // Value visible on the broadcast buses for a tag this cycle (ALU first).
  task automatic bus_value(input logic [RW-1:0] tag, output logic hit, output logic [31:0] val);
    hit = 1'b0; val = '0;
    if (alu_cdb_ready && alu_cdb_rob_id == tag) begin hit = 1'b1; val = alu_cdb_result; end
    else if (lsb_cdb_ready && lsb_cdb_rob_id == tag) begin hit = 1'b1; val = lsb_cdb_result; end
  endtask

  // Advance the model by one clock edge using the currently driven inputs.
  task automatic model_step();
    slot_t nxt [8];
    int pick, hole;
    logic hit;
    logic [31:0] val;
    if (!rdy) return;
    if (clear) begin
      for (int i = 0; i < 8; i++) slots[i].used = 1'b0;
      m_valid = 1'b0;
      return;
    end
    nxt = slots;
    pick = -1;
    for (int i = 0; i < 8; i++)
      if (pick < 0 && slots[i].used && !slots[i].wj && !slots[i].wk) pick = i;
    for (int i = 0; i < 8; i++) begin
      if (slots[i].used && slots[i].wj) begin
        bus_value(slots[i].tj, hit, val);
        if (hit) begin nxt[i].vj = val; nxt[i].wj = 1'b0; end
      end
      if (slots[i].used && slots[i].wk) begin
        bus_value(slots[i].tk, hit, val);
        if (hit) begin nxt[i].vk = val; nxt[i].wk = 1'b0; end
      end
    end
    if (pick >= 0) begin
      m_valid = 1'b1; m_op = slots[pick].op; m_v1 = slots[pick].vj;
      m_v2 = slots[pick].vk; m_rob = slots[pick].rob;
      nxt[pick].used = 1'b0;
    end else begin
      m_valid = 1'b0;
    end
    if (issue_valid && model_count() < 8) begin
      hole = -1;
      for (int i = 0; i < 8; i++) if (hole < 0 && !slots[i].used) hole = i;
      nxt[hole].used = 1'b1; nxt[hole].op = issue_op; nxt[hole].rob = issue_rob_id;
      nxt[hole].tj = issue_qj; nxt[hole].tk = issue_qk;
      nxt[hole].vj = issue_vj; nxt[hole].vk = issue_vk;
      nxt[hole].wj = issue_qj_busy; nxt[hole].wk = issue_qk_busy;
      if (issue_qj_busy) begin
        bus_value(issue_qj, hit, val);
        if (hit) begin nxt[hole].vj = val; nxt[hole].wj = 1'b0; end
      end
      if (issue_qk_busy) begin
        bus_value(issue_qk, hit, val);
        if (hit) begin nxt[hole].vk = val; nxt[hole].wk = 1'b0; end
      end
    end
    slots = nxt;
  endtask

  task automatic cmp_outputs();
    chk("alu_valid", alu_valid, m_valid);
    chk("alu_op", alu_op, m_op);
    chk("alu_v1", alu_v1, m_v1);
    chk("alu_v2", alu_v2, m_v2);
    chk("alu_rob_id", alu_rob_id, m_rob);
  endtask

  // One clock: check full (start of cycle), advance model, clock, compare.
  task automatic cycle();
    chk("full", full, model_count() == 8);
    model_step();
    @(posedge clk);
    #1;
    cmp_outputs();
  endtask

  task automatic idle();
    rdy = 1'b1; clear = 1'b0; issue_valid = 1'b0;
    issue_op = '0; issue_rob_id = '0; issue_qj_busy = 1'b0; issue_qk_busy = 1'b0;
    issue_qj = '0; issue_qk = '0; issue_vj = '0; issue_vk = '0;
    alu_cdb_ready = 1'b0; alu_cdb_rob_id = '0; alu_cdb_result = '0;
    lsb_cdb_ready = 1'b0; lsb_cdb_rob_id = '0; lsb_cdb_result = '0;
  endtask

  task automatic set_issue(input logic [4:0] op, input logic [RW-1:0] rob,
                           input logic jb, input logic [RW-1:0] tj, input logic [31:0] vj,
                           input logic kb, input logic [RW-1:0] tk, input logic [31:0] vk);
    issue_valid = 1'b1; issue_op = op; issue_rob_id = rob;
    issue_qj_busy = jb; issue_qj = tj; issue_vj = vj;
    issue_qk_busy = kb; issue_qk = tk; issue_vk = vk;
  endtask

  initial begin
    idle();
    rst = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", alu_valid, 0);
    chk("rst_op", alu_op, 0);
    chk("rst_v1", alu_v1, 0);
    chk("rst_rob", alu_rob_id, 0);
    chk("rst_full", full, 0);
    rst = 1'b1;

    // Ready issue: dispatch on the following edge, then idle.
    set_issue(5'd0, 4'd2, 1'b0, 4'd0, 32'd3, 1'b0, 4'd0, 32'd4);
    cycle();
    chk("rdy_not_yet", alu_valid, 0);
    idle(); cycle();
    chk("rdy_valid", alu_valid, 1);
    chk("rdy_v1", alu_v1, 3);
    chk("rdy_v2", alu_v2, 4);
    chk("rdy_rob", alu_rob_id, 2);
    cycle();
    chk("rdy_drop", alu_valid, 0);

    // Wakeup via LSB bus.
    set_issue(5'd3, 4'd1, 1'b1, 4'd5, 32'd0, 1'b0, 4'd0, 32'd7);
    cycle();
    idle(); cycle();
    chk("wake_wait", alu_valid, 0);
    lsb_cdb_ready = 1'b1; lsb_cdb_rob_id = 4'd5; lsb_cdb_result = 32'h100;
    cycle();
    chk("wake_bcast_edge", alu_valid, 0);
    idle(); cycle();
    chk("wake_valid", alu_valid, 1);
    chk("wake_v1", alu_v1, 32'h100);
    chk("wake_v2", alu_v2, 7);
    chk("wake_rob", alu_rob_id, 1);

    // Same-cycle bypass at issue.
    set_issue(5'd4, 4'd6, 1'b1, 4'd5, 32'd0, 1'b0, 4'd0, 32'd9);
    alu_cdb_ready = 1'b1; alu_cdb_rob_id = 4'd5; alu_cdb_result = 32'h55;
    cycle();
    idle(); cycle();
    chk("byp_valid", alu_valid, 1);
    chk("byp_v1", alu_v1, 32'h55);
    cycle();

    // Fill all 8 entries, waiting on tag 9.
    for (int i = 0; i < 8; i++) begin
      set_issue(5'(i), 4'(i), 1'b1, 4'd9, 32'd0, 1'b0, 4'd0, 32'(100 + i));
      cycle();
    end
    chk("full8", full, 1);
    set_issue(5'd31, 4'd15, 1'b0, 4'd0, 32'd1, 1'b0, 4'd0, 32'd2);
    cycle();
    idle();
    alu_cdb_ready = 1'b1; alu_cdb_rob_id = 4'd9; alu_cdb_result = 32'hA;
    cycle();
    idle();
    for (int i = 0; i < 8; i++) begin
      cycle();
      chk("full_seq_valid", alu_valid, 1);
      chk("full_seq_rob", alu_rob_id, i);
      chk("full_seq_v1", alu_v1, 32'hA);
      chk("full_seq_v2", alu_v2, 100 + i);
      if (i == 0) chk("full_drop", full, 0);
    end
    cycle();
    chk("full_after", alu_valid, 0);

    // Dual broadcast, ALU for j and LSB for k.
    set_issue(5'd7, 4'd8, 1'b1, 4'd3, 32'd0, 1'b1, 4'd4, 32'd0);
    cycle();
    idle();
    alu_cdb_ready = 1'b1; alu_cdb_rob_id = 4'd3; alu_cdb_result = 32'd11;
    lsb_cdb_ready = 1'b1; lsb_cdb_rob_id = 4'd4; lsb_cdb_result = 32'd22;
    cycle();
    idle(); cycle();
    chk("dual_v1", alu_v1, 11);
    chk("dual_v2", alu_v2, 22);

    // Both buses carry the same tag: ALU value wins.
    set_issue(5'd8, 4'd10, 1'b1, 4'd6, 32'd0, 1'b0, 4'd0, 32'd1);
    cycle();
    idle();
    alu_cdb_ready = 1'b1; alu_cdb_rob_id = 4'd6; alu_cdb_result = 32'hAA;
    lsb_cdb_ready = 1'b1; lsb_cdb_rob_id = 4'd6; lsb_cdb_result = 32'hBB;
    cycle();
    idle(); cycle();
    chk("prio_v1", alu_v1, 32'hAA);

    // Flush with simultaneous issue.
    for (int i = 0; i < 4; i++) begin
      set_issue(5'd1, 4'(i), 1'b1, 4'd12, 32'd0, 1'b0, 4'd0, 32'd0);
      cycle();
    end
    set_issue(5'd2, 4'd3, 1'b0, 4'd0, 32'd5, 1'b0, 4'd0, 32'd6);
    clear = 1'b1;
    cycle();
    chk("clr_valid", alu_valid, 0);
    chk("clr_full", full, 0);
    idle();
    alu_cdb_ready = 1'b1; alu_cdb_rob_id = 4'd12; alu_cdb_result = 32'd1;
    cycle();
    idle(); cycle();
    chk("clr_nodisp", alu_valid, 0);

    // Stall with a ready entry.
    set_issue(5'd9, 4'd11, 1'b0, 4'd0, 32'h77, 1'b0, 4'd0, 32'h78);
    cycle();
    idle(); rdy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (i == 1) set_issue(5'd1, 4'd1, 1'b0, 4'd0, 32'd1, 1'b0, 4'd0, 32'd1);
      cycle();
      chk("stall_hold", alu_valid, 0);
    end
    idle(); cycle();
    chk("stall_release", alu_valid, 1);
    chk("stall_v1", alu_v1, 32'h77);
    cycle();

    // Asynchronous reset mid-run with a dispatch just issued.
    set_issue(5'd1, 4'd2, 1'b1, 4'd13, 32'd0, 1'b0, 4'd0, 32'd0); cycle();
    set_issue(5'd1, 4'd3, 1'b1, 4'd13, 32'd0, 1'b0, 4'd0, 32'd0); cycle();
    set_issue(5'd1, 4'd1, 1'b0, 4'd0, 32'd1, 1'b0, 4'd0, 32'd2); cycle();
    idle(); cycle();
    chk("pre_rst_valid", alu_valid, 1);
    #2 rst = 1'b0;
    #1;
    chk("async_rst_valid", alu_valid, 0);
    chk("async_rst_full", full, 0);
    model_reset();
    #2 rst = 1'b1;
    alu_cdb_ready = 1'b1; alu_cdb_rob_id = 4'd13; alu_cdb_result = 32'd3;
    cycle();
    idle(); cycle();
    chk("post_rst_nodisp", alu_valid, 0);

    // Randomized traffic.
    for (int n = 0; n < 3000; n++) begin
      idle();
      rdy = ($urandom_range(0, 9) != 0);
      clear = ($urandom_range(0, 59) == 0);
      if ($urandom_range(0, 1) == 1)
        set_issue(5'($urandom), 4'($urandom_range(0, 15)),
                  1'($urandom), 4'($urandom_range(0, 7)), $urandom,
                  1'($urandom), 4'($urandom_range(0, 7)), $urandom);
      if ($urandom_range(0, 2) == 0) begin
        alu_cdb_ready = 1'b1; alu_cdb_rob_id = 4'($urandom_range(0, 7)); alu_cdb_result = $urandom;
      end
      if ($urandom_range(0, 2) == 0) begin
        lsb_cdb_ready = 1'b1; lsb_cdb_rob_id = 4'($urandom_range(0, 7)); lsb_cdb_result = $urandom;
      end
      cycle();
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/alu_reservation_station.md
Name: alu_reservation_station

Overview:
Reservation station that feeds the out-of-order core's ALU. It accepts renamed instructions from the issue stage, holds them until both operands are available, and snoops the ALU and LSB result broadcasts to capture pending operands. Each cycle it dispatches at most one ready entry to the ALU as op/v1/v2/rob_id with a valid strobe. The ALU's result then returns on the ALU broadcast bus.

Parameters:
RS_SIZE_WIDTH, 3, log2 of entry count (8 entries)
(ROB tag width is the codebase macro `ROB_SIZE_WIDTH, abbreviated RW below.)

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  reset, asynchronous, active-low (rst==0 resets)
rdy  in  1  global ready; 0 freezes all state
clear  in  1  mispredict flush, synchronous
issue_valid  in  1  new instruction present
issue_op  in  5  ALU opcode, passed through unchanged
issue_rob_id  in  RW  destination ROB tag
issue_qj_busy / issue_qk_busy  in  1 each  operand j/k still pending
issue_qj / issue_qk  in  RW each  producer ROB tag when pending
issue_vj / issue_vk  in  32 each  operand value when not pending
full  out  1  all entries busy (combinational from busy vector)
alu_cdb_ready, alu_cdb_rob_id, alu_cdb_result  in  1/RW/32  ALU broadcast
lsb_cdb_ready, lsb_cdb_rob_id, lsb_cdb_result  in  1/RW/32  LSB broadcast
alu_valid  out  1  dispatch strobe, registered
alu_op  out  5  dispatched opcode
alu_v1 / alu_v2  out  32 each  dispatched operands
alu_rob_id  out  RW  dispatched tag

Behaviour:
- Entry fields: busy, op, rob_id, vj, vk, qj, qk, rj, rk (rj/rk = operand ready).
- Reset (rst==0, async): all busy=0; alu_valid=0; alu_op, alu_v1, alu_v2, alu_rob_id=0; all entry fields 0.
- rdy==0: no register changes; issue ignored; outputs hold.
- clear==1 (with rdy==1): all busy<=0 and alu_valid<=0 at the edge; issue and dispatch that cycle are dropped; clear has priority over everything except reset.
- Issue: if issue_valid && !full, write the lowest-index free entry (busy as of the start of the cycle). If issue_valid && full, the issue is ignored; upstream must not do this.
- Issue bypass: if an operand is pending but its tag matches a valid broadcast in the same cycle, capture that broadcast's result and set the ready bit immediately.
- Snoop: every busy entry with a pending operand whose q matches alu_cdb_rob_id (alu_cdb_ready=1) or lsb_cdb_rob_id (lsb_cdb_ready=1) captures the result and sets r. Both buses are checked independently. If both match the same tag, the ALU bus wins.
- Dispatch: select the lowest-index entry with busy && rj && rk, judged on registered state at the start of the cycle.
  - At the edge: alu_valid<=1, outputs <= entry fields, entry busy<=0.
  - If nothing is eligible: alu_valid<=0, other outputs hold.
- Latency:
  - Issue with both operands ready at edge N → dispatch at edge N+1 (alu_valid high for cycle N+1..N+2).
  - Operand woken by broadcast at edge N → dispatch no earlier than edge N+1.
- Simultaneous issue and dispatch are allowed.
  - Issue cannot reuse the slot freed at the same edge; full reflects start-of-cycle state.
  - Dispatch never selects the entry being written that cycle.
- Exactly one dispatch per cycle maximum. Ordering is by index, not age.
- Values vj/vk of ready operands are never overwritten by later broadcasts.

Test Plan:
- Reset mid-run: fill 3 entries, drop rst to 0 asynchronously between edges → alu_valid=0 immediately, full=0; after release, no dispatch occurs.
- Ready issue: issue op=5'b00000, vj=3, vk=4, rob_id=2, both ready at edge 1 → edge 2: alu_valid=1, alu_v1=3, alu_v2=4, alu_rob_id=2. Edge 3: alu_valid=0.
- Wakeup: issue with qj_busy=1, qj=5, vk=7, rob_id=1. Then lsb_cdb_ready=1, rob_id=5, result=0x100 at edge 3 → dispatch at edge 4 with v1=0x100, v2=7. Also check same-cycle bypass: broadcast tag 5 in the issue cycle → dispatch at the next edge.
- Full: issue 8 entries each depending on tag 9 → full=1; a 9th issue is ignored. Broadcast tag 9 result 0xA → 8 consecutive dispatches, lowest index first, all v1=0xA; full drops after the first dispatch edge.
- Dual broadcast: entry waits on qj=3, qk=4. ALU bus tag 3=11 and LSB bus tag 4=22 in the same cycle → next edge dispatches v1=11, v2=22.
- Flush/stall: 4 entries pending, assert clear together with issue_valid → all busy=0, alu_valid=0, new issue dropped. Hold rdy=0 with a ready entry → no dispatch until rdy returns to 1.
